mem_access_stage: RTL and testbench

//   MEM-stage memory access unit of the 5-stage ARM32 pipeline. Accepts one instruction per

---
 rtl/mem_access_stage_if.sv | 34 +++
 rtl/mem_access_stage.sv | 117 +++++++++++
 tb/tb_mem_access_stage.sv | 234 +++++++++++++++++++++++
 3 files changed

// File: rtl/mem_access_stage_if.sv
// EX -> MEM handshake, data-memory port and MEM/WB register bundle for mem_access_stage.
// The master modport is the stage's view; slave is the surrounding pipeline/memory view.
interface mem_access_stage_if;
  logic        flush;
  logic        ex_valid;
  logic        ex_ready;
  logic [31:0] ex_inst;
  logic [31:0] ex_addr;
  logic [31:0] ex_store_data;
  logic        dmem_req;
  logic        dmem_we;
  logic [3:0]  dmem_be;
  logic [31:0] dmem_addr;
  logic [31:0] dmem_wdata;
  logic        dmem_ack;
  logic [31:0] dmem_rdata;
  logic        wb_valid;
  logic [31:0] wb_inst;
  logic [31:0] wb_mem_addr;
  logic [31:0] wb_mem_rdata;
  logic        wb_fault;

  modport master (
    input  flush, ex_valid, ex_inst, ex_addr, ex_store_data, dmem_ack, dmem_rdata,
    output ex_ready, dmem_req, dmem_we, dmem_be, dmem_addr, dmem_wdata,
           wb_valid, wb_inst, wb_mem_addr, wb_mem_rdata, wb_fault
  );

  modport slave (
    output flush, ex_valid, ex_inst, ex_addr, ex_store_data, dmem_ack, dmem_rdata,
    input  ex_ready, dmem_req, dmem_we, dmem_be, dmem_addr, dmem_wdata,
           wb_valid, wb_inst, wb_mem_addr, wb_mem_rdata, wb_fault
  );
endinterface

// File: rtl/mem_access_stage.sv
// MEM-stage memory access unit: issues LDR/STR/LDRB/STRB on the data port, waits for a
// variable-latency ack (with optional timeout) and loads the MEM/WB register.
module mem_access_stage #(
  parameter bit          BIG_ENDIAN = 1'b0,
  parameter int unsigned TIMEOUT    = 16,
  parameter int unsigned CNT_W      = 5
) (
  input logic                clk,
  input logic                rst_n,
  mem_access_stage_if.master bus
);

  typedef enum logic {IDLE, ACCESS} state_t;

  state_t           state;
  logic [CNT_W-1:0] cnt;
  logic             squash;
  logic [31:0]      inst_r;
  logic [31:0]      addr_r;

  logic        accept;
  logic        is_sdt;
  logic        is_load;
  logic        is_byte;
  logic        timeout_hit;
  logic        kill;
  logic [3:0]  be_next;
  logic [31:0] wdata_next;

  always_comb begin
    accept      = bus.ex_valid & bus.ex_ready & ~bus.flush;
    is_sdt      = (bus.ex_inst[27:26] == 2'b01);
    is_load     = bus.ex_inst[20];
    is_byte     = bus.ex_inst[22];
    timeout_hit = (TIMEOUT != 0) && (cnt == CNT_W'(TIMEOUT - 1));
    // A flush arriving in the completion cycle squashes the retirement as well.
    kill        = squash | bus.flush;
    be_next     = is_byte ? (4'b0001 << bus.ex_addr[1:0]) : 4'hF;
    wdata_next  = '0;
    if (!is_load) begin
      if (is_byte)
        wdata_next = {4{bus.ex_store_data[7:0]}};
      else if (BIG_ENDIAN)
        wdata_next = {bus.ex_store_data[7:0],   bus.ex_store_data[15:8],
                      bus.ex_store_data[23:16], bus.ex_store_data[31:24]};
      else
        wdata_next = bus.ex_store_data;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state            <= IDLE;
      cnt              <= '0;
      squash           <= 1'b0;
      inst_r           <= '0;
      addr_r           <= '0;
      bus.ex_ready     <= 1'b1;
      bus.dmem_req     <= 1'b0;
      bus.dmem_we      <= 1'b0;
      bus.dmem_be      <= '0;
      bus.dmem_addr    <= '0;
      bus.dmem_wdata   <= '0;
      bus.wb_valid     <= 1'b0;
      bus.wb_inst      <= '0;
      bus.wb_mem_addr  <= '0;
      bus.wb_mem_rdata <= '0;
      bus.wb_fault     <= 1'b0;
    end else begin
      bus.wb_valid <= 1'b0;
      unique case (state)
        IDLE: begin
          if (accept) begin
            cnt    <= '0;
            squash <= 1'b0;
            if (is_sdt) begin
              state          <= ACCESS;
              bus.ex_ready   <= 1'b0;
              bus.dmem_req   <= 1'b1;
              bus.dmem_we    <= ~is_load;
              bus.dmem_be    <= be_next;
              bus.dmem_addr  <= {bus.ex_addr[31:2], 2'b00};
              bus.dmem_wdata <= wdata_next;
              inst_r         <= bus.ex_inst;
              addr_r         <= bus.ex_addr;
            end else begin
              bus.wb_valid     <= 1'b1;
              bus.wb_inst      <= bus.ex_inst;
              bus.wb_mem_addr  <= bus.ex_addr;
              bus.wb_mem_rdata <= '0;
              bus.wb_fault     <= 1'b0;
            end
          end
        end
        ACCESS: begin
          if (bus.dmem_ack || timeout_hit) begin
            state        <= IDLE;
            bus.ex_ready <= 1'b1;
            bus.dmem_req <= 1'b0;
            if (!kill) begin
              bus.wb_valid     <= 1'b1;
              bus.wb_inst      <= inst_r;
              bus.wb_mem_addr  <= addr_r;
              bus.wb_mem_rdata <= (bus.dmem_ack && !bus.dmem_we) ? bus.dmem_rdata : '0;
              bus.wb_fault     <= ~bus.dmem_ack;
            end
          end else begin
            cnt <= cnt + CNT_W'(1);
            if (bus.flush) squash <= 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mem_access_stage.sv
// Randomised transaction-level bench for mem_access_stage: two instances (little-endian,
// timeout 16 / big-endian, timeout 4) share the stimulus, only the selected one is active.
module tb_mem_access_stage;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  bit          sel = 1'b0;
  logic        flush = 1'b0;
  logic        ex_valid = 1'b0;
  logic [31:0] ex_inst = '0;
  logic [31:0] ex_addr = '0;
  logic [31:0] ex_store_data = '0;
  logic        dmem_ack = 1'b0;
  logic [31:0] dmem_rdata = '0;

  int unsigned n_checks = 0;
  int unsigned n_fail   = 0;

  mem_access_stage_if if0 ();
  mem_access_stage_if if1 ();

  assign if0.flush = flush;           assign if1.flush = flush;
  assign if0.ex_valid = ex_valid & ~sel; assign if1.ex_valid = ex_valid & sel;
  assign if0.ex_inst = ex_inst;       assign if1.ex_inst = ex_inst;
  assign if0.ex_addr = ex_addr;       assign if1.ex_addr = ex_addr;
  assign if0.ex_store_data = ex_store_data; assign if1.ex_store_data = ex_store_data;
  assign if0.dmem_ack = dmem_ack & ~sel; assign if1.dmem_ack = dmem_ack & sel;
  assign if0.dmem_rdata = dmem_rdata; assign if1.dmem_rdata = dmem_rdata;

  mem_access_stage #(.BIG_ENDIAN(1'b0), .TIMEOUT(16), .CNT_W(5)) dut0 (
    .clk(clk), .rst_n(rst_n), .bus(if0));
  mem_access_stage #(.BIG_ENDIAN(1'b1), .TIMEOUT(4), .CNT_W(3)) dut1 (
    .clk(clk), .rst_n(rst_n), .bus(if1));

  wire        o_ready = sel ? if1.ex_ready     : if0.ex_ready;
  wire        o_req   = sel ? if1.dmem_req     : if0.dmem_req;
  wire        o_we    = sel ? if1.dmem_we      : if0.dmem_we;
  wire [3:0]  o_be    = sel ? if1.dmem_be      : if0.dmem_be;
  wire [31:0] o_addr  = sel ? if1.dmem_addr    : if0.dmem_addr;
  wire [31:0] o_wdata = sel ? if1.dmem_wdata   : if0.dmem_wdata;
  wire        o_wbv   = sel ? if1.wb_valid     : if0.wb_valid;
  wire [31:0] o_wbi   = sel ? if1.wb_inst      : if0.wb_inst;
  wire [31:0] o_wba   = sel ? if1.wb_mem_addr  : if0.wb_mem_addr;
  wire [31:0] o_wbd   = sel ? if1.wb_mem_rdata : if0.wb_mem_rdata;
  wire        o_wbf   = sel ? if1.wb_fault     : if0.wb_fault;

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] mk_sdt(input bit load, input bit byte_op);
    logic [31:0] i = $urandom;
    i[27:26] = 2'b01;
    i[22] = byte_op;
    i[20] = load;
    return i;
  endfunction

  function automatic logic [31:0] mk_other();
    logic [31:0] i = $urandom;
    logic [1:0]  k = 2'($urandom_range(0, 2));
    i[27:26] = (k == 2'd0) ? 2'b00 : ((k == 2'd1) ? 2'b10 : 2'b11);
    return i;
  endfunction

  // Expected data-port image of a store, from the lane rules
  function automatic logic [31:0] exp_wdata(input logic [31:0] d, input bit byte_op, input bit big);
    logic [31:0] r;
    if (byte_op) return {24'd0, d[7:0]} * 32'h0101_0101;
    if (!big) return d;
    r = '0;
    for (int unsigned b = 0; b < 4; b++) r[8*b +: 8] = d[8*(3-b) +: 8];
    return r;
  endfunction

  task automatic idle_cycle();
    dmem_ack   = ($urandom_range(0, 3) == 0);
    dmem_rdata = $urandom;
    @(negedge clk);
    dmem_ack = 1'b0;
    chk("idle_req", {31'd0, o_req}, 32'd0);
    chk("idle_wbv", {31'd0, o_wbv}, 32'd0);
    chk("idle_ready", {31'd0, o_ready}, 32'd1);
  endtask

  task automatic non_sdt(input logic [31:0] inst, input logic [31:0] addr);
    ex_valid = 1'b1; ex_inst = inst; ex_addr = addr; ex_store_data = $urandom;
    @(negedge clk);
    ex_valid = 1'b0;
    chk("alu_wbv", {31'd0, o_wbv}, 32'd1);
    chk("alu_inst", o_wbi, inst);
    chk("alu_addr", o_wba, addr);
    chk("alu_rdata", o_wbd, 32'd0);
    chk("alu_fault", {31'd0, o_wbf}, 32'd0);
    chk("alu_req", {31'd0, o_req}, 32'd0);
  endtask

  task automatic entry_flush(input logic [31:0] inst);
    ex_valid = 1'b1; ex_inst = inst; ex_addr = $urandom; flush = 1'b1;
    @(negedge clk);
    ex_valid = 1'b0; flush = 1'b0;
    chk("eflush_req", {31'd0, o_req}, 32'd0);
    chk("eflush_wbv", {31'd0, o_wbv}, 32'd0);
    chk("eflush_ready", {31'd0, o_ready}, 32'd1);
  endtask

  // ack_at: request cycle (1-based) carrying the ack, 0 = never; flush_at likewise
  task automatic sdt(input logic [31:0] inst, input logic [31:0] addr, input logic [31:0] data,
                     input int unsigned ack_at, input logic [31:0] rdata,
                     input int unsigned flush_at, input bit late_ack);
    int unsigned tmo = sel ? 4 : 16;
    bit load = inst[20];
    bit byte_op = inst[22];
    int unsigned exp_cyc;
    bit fault;
    bit retire;
    int unsigned k = 0;
    if (ack_at != 0 && ack_at <= tmo) begin exp_cyc = ack_at; fault = 1'b0; end
    else begin exp_cyc = tmo; fault = 1'b1; end
    retire = !(flush_at != 0 && flush_at <= exp_cyc);

    chk("sdt_ready_in", {31'd0, o_ready}, 32'd1);
    ex_valid = 1'b1; ex_inst = inst; ex_addr = addr; ex_store_data = data;
    @(negedge clk);
    ex_valid = 1'b0; ex_inst = $urandom; ex_addr = $urandom; ex_store_data = $urandom;
    chk("sdt_wbv_acc", {31'd0, o_wbv}, 32'd0);
    while (o_req && k < 40) begin
      k++;
      chk("req_addr", o_addr, {addr[31:2], 2'b00});
      chk("req_be", {28'd0, o_be}, byte_op ? (32'd1 << addr[1:0]) : 32'hF);
      chk("req_we", {31'd0, o_we}, {31'd0, !load});
      if (!load) chk("req_wdata", o_wdata, exp_wdata(data, byte_op, sel));
      chk("req_ready", {31'd0, o_ready}, 32'd0);
      dmem_ack   = (k == ack_at);
      dmem_rdata = (k == ack_at) ? rdata : $urandom;
      flush      = (k == flush_at);
      @(negedge clk);
      dmem_ack = 1'b0; flush = 1'b0;
    end
    chk("req_cycles", k, exp_cyc);
    chk("done_ready", {31'd0, o_ready}, 32'd1);
    chk("done_wbv", {31'd0, o_wbv}, {31'd0, retire});
    if (retire) begin
      chk("wb_inst", o_wbi, inst);
      chk("wb_addr", o_wba, addr);
      chk("wb_rdata", o_wbd, (load && !fault) ? rdata : 32'd0);
      chk("wb_fault", {31'd0, o_wbf}, {31'd0, fault});
    end
    if (late_ack) begin
      dmem_ack = 1'b1; dmem_rdata = $urandom;
      @(negedge clk);
      dmem_ack = 1'b0;
      chk("late_wbv", {31'd0, o_wbv}, 32'd0);
      chk("late_req", {31'd0, o_req}, 32'd0);
    end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    @(negedge clk);
    chk("rst_ready", {31'd0, o_ready}, 32'd1);
    chk("rst_req", {31'd0, o_req}, 32'd0);
    chk("rst_wbv", {31'd0, o_wbv}, 32'd0);
    chk("rst_wbd", o_wbd, 32'd0);
    chk("rst_wbf", {31'd0, o_wbf}, 32'd0);
    rst_n = 1'b1;
    @(negedge clk);

    // Directed cases
    sdt(32'hE591_0000, 32'h0000_0104, 32'h0, 3, 32'hA1B2_C3D4, 0, 1'b0);
    sdt(32'hE5C1_0000, 32'h0000_0203, 32'h0000_00EE, 1, 32'h0, 0, 1'b0);
    sdt(32'hE581_0000, 32'h0000_0040, 32'h1122_3344, 2, 32'h0, 0, 1'b0);
    non_sdt(32'hE081_0002, 32'h0000_1234);
    idle_cycle();
    sel = 1'b1;
    sdt(32'hE581_0000, 32'h0000_0040, 32'h1122_3344, 1, 32'h0, 0, 1'b0);
    sdt(32'hE591_0000, 32'h0000_0300, 32'h0, 0, 32'h0, 0, 1'b1);
    sel = 1'b0;
    sdt(32'hE591_0000, 32'h0000_0500, 32'h0, 3, 32'hDEAD_BEEF, 1, 1'b0);
    entry_flush(32'hE591_0000);

    // Asynchronous reset mid-access, then an ALU op retires right away
    ex_valid = 1'b1; ex_inst = 32'hE591_0000; ex_addr = 32'h600;
    @(negedge clk);
    ex_valid = 1'b0;
    @(negedge clk);
    chk("pre_rst_req", {31'd0, o_req}, 32'd1);
    rst_n = 1'b0;
    #1;
    chk("async_rst_req", {31'd0, o_req}, 32'd0);
    chk("async_rst_ready", {31'd0, o_ready}, 32'd1);
    @(negedge clk);
    rst_n = 1'b1;
    dmem_ack = 1'b1;
    non_sdt(32'hE080_0001, 32'h0000_0777);
    dmem_ack = 1'b0;
    idle_cycle();

    // Randomised traffic on both instances
    for (int n = 0; n < 250; n++) begin
      int unsigned kind = $urandom_range(0, 9);
      sel = ($urandom_range(0, 2) == 0);
      if (kind < 6) begin
        int unsigned ack_at;
        int unsigned fl;
        ack_at = ($urandom_range(0, 7) == 0) ? 0 : $urandom_range(1, sel ? 6 : 7);
        fl = ($urandom_range(0, 6) == 0) ? $urandom_range(1, 4) : 0;
        sdt(mk_sdt($urandom_range(0, 1) == 1, $urandom_range(0, 1) == 1), $urandom, $urandom,
            ack_at, $urandom, fl, $urandom_range(0, 5) == 0);
      end else if (kind < 8) begin
        non_sdt(mk_other(), $urandom);
      end else if (kind == 8) begin
        entry_flush($urandom_range(0, 1) == 1 ? mk_sdt(1'b1, 1'b0) : mk_other());
      end else begin
        idle_cycle();
      end
    end

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
